// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: rv32 fetch stage with credit-limited requests and an in-order instruction FIFO; FETCH_MISALIGN_CHK_EN adds a misaligned-redirect trap
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        dec_misaligned
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
`ifdef FETCH_MISALIGN_CHK_EN
  localparam int EW = 65;
`else
  localparam int EW = 64;
`endif
  logic [CW-1:0] count, outstanding, discard, out_next, wr_idx;
  logic [31:0] fetch_pc, rsp_pc;
  logic [EW-1:0] fifo_q [FIFO_DEPTH];
  logic [EW-1:0] push_data;
  logic req_fire, keep, push, pop, halt, mis_pend;
  // buffered words plus in-flight requests never exceed the buffer, so a push always has room
  always_comb begin
    imem_req_valid = !rst && !redirect_valid && !halt &&
                     (({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(FIFO_DEPTH));
    imem_addr = fetch_pc;
    req_fire = imem_req_valid && imem_req_ready;
    keep = imem_rsp_valid && discard == '0;
    push = !redirect_valid && (keep || (mis_pend && discard == '0));
    pop = dec_valid && dec_ready && !redirect_valid;
    out_next = outstanding - CW'(imem_rsp_valid);
    wr_idx = count - CW'(pop);
    dec_valid = count != '0;
    dec_instr = fifo_q[0][63:32];
    dec_pc = fifo_q[0][31:0];
  end
`ifdef FETCH_MISALIGN_CHK_EN
  logic [31:0] mis_pc;
  assign push_data = keep ? {1'b0, imem_rsp_data, rsp_pc} : {1'b1, 32'h0000_0013, mis_pc};
  assign dec_misaligned = fifo_q[0][64];
  // a misaligned target stops fetch and queues one flagged NOP once stale words have drained
  always_ff @(posedge clk) begin
    if (rst) begin
      halt <= 1'b0;
      mis_pend <= 1'b0;
      mis_pc <= '0;
    end else if (redirect_valid) begin
      halt <= |redirect_pc[1:0];
      mis_pend <= |redirect_pc[1:0];
      mis_pc <= redirect_pc;
    end else if (push && !keep) begin
      mis_pend <= 1'b0;
    end
  end
`else
  assign push_data = {imem_rsp_data, rsp_pc};
  assign halt = 1'b0;
  assign mis_pend = 1'b0;
`endif
  // pc, credit and discard bookkeeping plus shift FIFO; a redirect overrides push and pop
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      assert (!(push && !pop && count == CW'(FIFO_DEPTH)));
      outstanding <= out_next + CW'(req_fire);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~32'h3;
        rsp_pc <= redirect_pc & ~32'h3;
        discard <= out_next;
        count <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && discard != '0) discard <= discard - CW'(1);
        if (keep) rsp_pc <= rsp_pc + 32'd4;
        count <= count + CW'(push) - CW'(pop);
        for (int i = 0; i < FIFO_DEPTH; i++)
          if (push && CW'(i) == wr_idx) fifo_q[i] <= push_data;
          else if (pop) fifo_q[i] <= fifo_q[(i + 1) % FIFO_DEPTH];
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized bench checking instr_fetch_unit against a stream-level model and an in-order memory
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h100;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic dec_valid, dec_ready = 1'b0;
  logic [31:0] dec_instr, dec_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic dec_misaligned;
`endif
  always #5 clk = ~clk;
  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    , .dec_misaligned(dec_misaligned)
`endif
  );
  typedef struct { logic [31:0] addr; int ret; int epoch; } req_t;
  req_t mq[$];
  logic [31:0] del_pcs[$];
  int tests = 0, fails = 0, cyc = 0, epoch = 0, buffered = 0, last_ret = 0;
  int lat_lo = 1, lat_hi = 1, ndel = 0, nacc = 0;
  logic [31:0] exp_fetch, exp_dec_pc;
  logic exp_mis = 1'b0, halted = 1'b0, mis_pending = 1'b0, fired = 1'b0;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_redirect(input logic [31:0] rpc);
    epoch++;
    buffered = 0;
    exp_fetch = rpc & ~32'h3;
    exp_dec_pc = rpc & ~32'h3;
    exp_mis = 1'b0;
    halted = 1'b0;
    mis_pending = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    if (rpc[1:0] != 2'b00) begin
      halted = 1'b1;
      mis_pending = 1'b1;
      exp_dec_pc = rpc;
      exp_mis = 1'b1;
    end
`endif
  endtask

  task automatic cycle(input logic rdy, input logic drdy, input logic rv, input logic [31:0] rpc, input logic rv_on_rsp);
    req_t r;
    int inflight;
    logic rv_e;
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    r = '{default: 0};
    if (mq.size() > 0 && mq[0].ret <= cyc) begin
      r = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data = memdata(r.addr);
    end
    rv_e = rv || (rv_on_rsp && imem_rsp_valid && dec_valid);
    fired = rv_e;
    redirect_valid = rv_e;
    redirect_pc = rpc;
    imem_req_ready = rdy;
    dec_ready = drdy;
    #1;
    inflight = mq.size() + int'(imem_rsp_valid);
    chk("dec_valid", dec_valid, buffered > 0);
    chk("req_valid", imem_req_valid, !rv_e && !halted && (buffered + inflight < DEPTH));
    if (dec_valid && drdy && !rv_e) begin
      chk("dec_pc", dec_pc, exp_dec_pc);
      chk("dec_instr", dec_instr, exp_mis ? 32'h0000_0013 : memdata(exp_dec_pc));
`ifdef FETCH_MISALIGN_CHK_EN
      chk("dec_misaligned", dec_misaligned, exp_mis);
`endif
      del_pcs.push_back(dec_pc);
      exp_dec_pc += 32'd4;
      buffered--;
      ndel++;
    end
    if (imem_req_valid && imem_req_ready) begin
      int ret;
      chk("imem_addr", imem_addr, exp_fetch);
      ret = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (ret <= last_ret) ret = last_ret + 1;
      last_ret = ret;
      mq.push_back('{imem_addr, ret, epoch});
      exp_fetch += 32'd4;
      nacc++;
    end
    if (rv_e) model_redirect(rpc);
    else if (imem_rsp_valid && r.epoch == epoch) buffered++;
    else if (mis_pending && inflight == 0) begin
      buffered++;
      mis_pending = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = $urandom;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready = 1'b1;
    #1 chk("req_valid_in_reset", imem_req_valid, 0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1 chk("req_valid_in_reset2", imem_req_valid, 0);
    mq.delete();
    epoch++;
    buffered = 0;
    last_ret = 0;
    exp_fetch = RESET_PC;
    exp_dec_pc = RESET_PC;
    exp_mis = 1'b0;
    halted = 1'b0;
    mis_pending = 1'b0;
    cyc += 2;
    @(negedge clk);
    rst = 1'b0;
    imem_req_ready = 1'b0;
    dec_ready = 1'b0;
    #1;
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_instr", dec_instr, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("rst_dec_misaligned", dec_misaligned, 0);
`endif
    chk("rst_req_valid", imem_req_valid, 1);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, a0, got;
    logic [31:0] rpc;
    do_reset();
    del_pcs.delete();
    repeat (12) cycle(1, 1, 0, 0, 0);
    chk("t1_count", del_pcs.size() >= 3, 1);
    chk("t1_pc0", del_pcs[0], 32'h100);
    chk("t1_pc1", del_pcs[1], 32'h104);
    chk("t1_pc2", del_pcs[2], 32'h108);
    a0 = nacc;
    repeat (10) cycle(1, 0, 0, 0, 0);
    chk("t2_stall_accepts", (nacc - a0) <= DEPTH, 1);
    chk("t2_req_blocked", imem_req_valid, 0);
    repeat (10) cycle(1, 1, 0, 0, 0);
    lat_lo = 3;
    lat_hi = 3;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      cycle(1, 1, 0, 0, 0);
      if (mq.size() == 2) got = 1;
    end
    chk("t3_two_inflight", got, 1);
    cycle(1, 1, 1, 32'h200, 0);
    del_pcs.delete();
    for (int k = 0; k < 20 && del_pcs.size() == 0; k++) cycle(1, 1, 0, 0, 0);
    chk("t3_first_pc", del_pcs.size() > 0 ? del_pcs[0] : 32'hDEAD_BEEF, 32'h200);
    lat_lo = 1;
    lat_hi = 1;
    repeat (6) cycle(1, 1, 0, 0, 0);
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      cycle(1, 1, 0, 32'h400, 1);
      if (fired) got = 1;
    end
    chk("t4_fired", got, 1);
    cycle(1, 1, 0, 0, 0);
    chk("t4_valid_next", dec_valid, 0);
    del_pcs.delete();
    for (int k = 0; k < 10 && del_pcs.size() == 0; k++) cycle(1, 1, 0, 0, 0);
    chk("t4_first_pc", del_pcs.size() > 0 ? del_pcs[0] : 32'hDEAD_BEEF, 32'h400);
    repeat (4) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 32'hFFFF_FFF8, 0);
    del_pcs.delete();
    got = 0;
    for (int k = 1; k <= 10 && got == 0; k++) begin
      cycle(1, 1, 0, 0, 0);
      if (dec_valid) got = k;
    end
    chk("t5_latency", got, 3);
    for (int k = 0; k < 20 && del_pcs.size() < 3; k++) cycle(1, 1, 0, 0, 0);
    chk("t5_count", del_pcs.size() >= 3, 1);
    chk("t5_pc0", del_pcs[0], 32'hFFFF_FFF8);
    chk("t5_pc1", del_pcs[1], 32'hFFFF_FFFC);
    chk("t5_pc2", del_pcs[2], 32'h0000_0000);
`ifdef FETCH_MISALIGN_CHK_EN
    lat_lo = 3;
    lat_hi = 3;
    repeat (3) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 32'h202, 0);
    del_pcs.delete();
    a0 = nacc;
    repeat (15) cycle(1, 1, 0, 0, 0);
    chk("t6_single_entry", del_pcs.size(), 1);
    chk("t6_pc", del_pcs.size() > 0 ? del_pcs[0] : 32'hDEAD_BEEF, 32'h202);
    chk("t6_no_requests", nacc - a0, 0);
    cycle(1, 1, 1, 32'h300, 0);
    repeat (10) cycle(1, 1, 0, 0, 0);
`else
    cycle(1, 1, 1, 32'h203, 0);
    del_pcs.delete();
    for (int k = 0; k < 20 && del_pcs.size() == 0; k++) cycle(1, 1, 0, 0, 0);
    chk("t6_forced_align", del_pcs.size() > 0 ? del_pcs[0] : 32'hDEAD_BEEF, 32'h200);
`endif
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 2500; i++) begin
      rpc = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
`endif
      cycle($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(24) == 0, rpc, 0);
    end
    n0 = ndel;
    lat_lo = 2;
    lat_hi = 2;
    repeat (5) cycle(1, 1, 0, 0, 0);
    do_reset();
    del_pcs.delete();
    lat_lo = 1;
    lat_hi = 3;
    repeat (30) cycle(1, 1, 0, 0, 0);
    chk("t7_progress", ndel > n0, 1);
    chk("t7_restart_pc", del_pcs.size() > 0 ? del_pcs[0] : 32'hDEAD_BEEF, RESET_PC);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage of the rv32 core. It is the producer end of the fetch-to-decode interface.
- Owns the fetch PC and issues word requests to instruction memory.
- Buffers returned words with their PCs in a small FIFO.
- Presents {instruction, pc} to decode over a valid/ready handshake.
- On a redirect from execute, it discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on in-flight requests plus buffered words (range 2..8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response word valid. Responses return in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  response instruction word.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  new fetch target.
- dec_valid  out  1  FIFO head valid.
- dec_ready  in  1  decode consumes the head.
- dec_instr  out  32  head instruction word.
- dec_pc  out  32  PC of dec_instr.

Behaviour:
Reset (rst high at a clock edge):
- fetch_pc=RESET_PC, rsp_pc=RESET_PC.
- outstanding=0, discard=0, FIFO empty.
- dec_valid=0, dec_instr=0, dec_pc=0.
- imem_req_valid=0 for the whole reset cycle.
- Responses arriving during reset are ignored.
- Reset mid-operation abandons all in-flight requests; the memory must also be reset.

Request issue:
- Issue condition: imem_req_valid = !rst && !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH).
- imem_addr = fetch_pc.
- On handshake: fetch_pc += 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000; outstanding += 1.
- This interface permits withdrawing a request (valid dropping without ready) only in a redirect cycle.

Response handling:
- Each response decrements outstanding.
- If discard > 0: the word is dropped and discard -= 1.
- Otherwise: push {imem_rsp_data, rsp_pc} into the FIFO and advance rsp_pc += 4 (same wrap rule).
- Overflow is impossible because of the credit rule. Push-when-full is a design error; flag it with an assertion.

Decode side:
- dec_* outputs are driven directly from FIFO head registers.
- Response-to-dec_valid latency is 1 cycle.
- Pop on dec_valid && dec_ready. Simultaneous push and pop are allowed at any occupancy, including full.

Redirect (redirect_valid high), which has priority over pop and push:
- FIFO flushed; dec_valid=0 from the next cycle.
- fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
- discard = outstanding_next, where outstanding_next = outstanding minus any response arriving in the same cycle, which is itself dropped. All remaining in-flight words therefore become stale.
- No request is issued in the redirect cycle.
- Back-to-back redirects: the last one wins; discard is recomputed each time.

Minimum redirect-to-dec_valid latency, with a 1-cycle memory and ready always high, is 3 cycles:
- request in cycle +1, response in cycle +2, dec_valid in cycle +3.
- Steady-state throughput is 1 instruction per cycle.

Optional Feature:
Macro FETCH_MISALIGN_CHK_EN.

Defined:
- Adds port dec_misaligned (out, 1).
- On a redirect with redirect_pc[1:0] != 0:
  - No requests are issued.
  - After stale discards, a single entry is pushed: instr=32'h0000_0013 (NOP), pc=redirect_pc unmodified, misaligned=1.
  - Fetch then idles until the next redirect.
- dec_misaligned is 0 for all normal entries and 0 after reset.

Undefined:
- No port.
- redirect_pc[1:0] are silently forced to 00.

Test Plan:
- Reset with RESET_PC=32'h100, 1-cycle memory, dec_ready=1 -> dec_pc sequence 100,104,108, one per cycle after the 2-cycle pipeline fill; dec_instr matches the memory model.
- dec_ready=0 for 10 cycles -> at most FIFO_DEPTH accepted requests, imem_req_valid=0 once full. Release -> words delivered in order with no loss or duplication.
- 3-cycle memory latency with 2 requests in flight, then redirect_pc=32'h200 -> both stale responses dropped; next dec_pc=200 with data from address 200.
- Redirect in the same cycle as a response and a decode pop -> response dropped, dec_valid=0 next cycle, first delivered pc equals the target.
- fetch_pc starting at 32'hFFFF_FFF8 -> dec_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With FETCH_MISALIGN_CHK_EN, redirect_pc=32'h202 -> a single entry with dec_instr=0000_0013, dec_pc=202, dec_misaligned=1, and no imem requests until the next redirect.
